mul_4bits_seq: RTL and testbench
================================

MUL_4BITS_SEQ -- requirements
Module: mul_4bits_seq

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 4 bits and the product width at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin a multiplication; sampled on rising clk.
REQ-005 i0  input  4  unsigned multiplicand; sampled only on the accepting edge.
REQ-006 i1  input  4  unsigned multiplier; sampled only on the accepting edge.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse; product is valid and updated.
REQ-009 product  output  8  registered result i0*i1 of the last completed operation.

Function
REQ-010 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL:
- capture A<=i0, Q<=i1, P<=4'b0 and step counter<=0;
- enter BUSY.
REQ-012 In IDLE with start=0, the state SHALL remain IDLE and all registers SHALL hold.
REQ-013 Each rising edge in BUSY SHALL perform one shift-add step:
- if Q[0]=1, {c,s}=P+A, computed by the team's 4-bit ripple-carry adder fa_4bits with cin=0;
- otherwise {c,s}={0,P};
- then {P,Q}<={c,s,Q[3:1]} (9-bit right shift into the 8-bit {P,Q});
- counter increments by 1.
REQ-014 On the fourth BUSY step (counter=3), the block SHALL:
- load product<={P',Q'} (the post-shift values);
- enter DONE.
REQ-015 DONE SHALL last exactly one cycle and SHALL then return unconditionally to IDLE.
REQ-016 busy SHALL be 1 in BUSY only; done SHALL be 1 in DONE only. Both SHALL be registered and decoded from state.
REQ-017 Latency: with start accepted at edge E0, busy SHALL be high for the 4 cycles after E0, and done and the new product SHALL be visible after edge E4.
REQ-018 start SHALL be ignored in BUSY and DONE. No queuing: a start held high SHALL next be accepted at the first edge in IDLE, which is E5+1.
REQ-019 product SHALL change only at the DONE-entry edge or at reset. It SHALL hold its previous value throughout BUSY and IDLE.
REQ-020 Arithmetic SHALL be unsigned. The maximum result 15*15=225 SHALL fit in 8 bits with no overflow indication.
REQ-021 Changes to i0/i1 after the accepting edge SHALL NOT affect the operation in progress.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock, force:
- state=IDLE;
- busy=0, done=0, product=8'h00;
- A, Q, P and counter to 0.
REQ-023 Reset asserted mid-operation (BUSY or DONE) SHALL abort the operation, and no done pulse SHALL follow.
REQ-024 After rst_n deasserts, the first start SHALL be accepted at the next rising edge on which start=1.

Verification
REQ-025 Reset then idle: rst_n low, then high, start=0 for 10 cycles -> busy=0, done=0, product=8'h00 throughout.
REQ-026 Corner values: i0=15, i1=15, start pulse -> busy high 4 cycles, then done=1 for 1 cycle with product=8'hE1 (225); i0=0, i1=9 -> product=8'h00.
REQ-027 Hold and isolation: i0=10, i1=12, start pulse, with i0/i1 changed to 3/3 during BUSY -> product=8'h78 (120); product holds 8'h78 until the next done.
REQ-028 Held start: start held high continuously with i0=1, i1=1 -> done pulses every 6 cycles, product=8'h01, start ignored while busy=1.
REQ-029 Reset mid-operation: i0=7, i1=6 started, rst_n pulsed low at the 2nd BUSY cycle -> outputs 0 immediately, no done; restart with i0=7, i1=6 -> product=8'h2A (42).
REQ-030 Exhaustive: all 256 (i0,i1) pairs -> product = i0*i1 exactly 4 busy cycles after each accepted start.

Source files
------------

// File: rtl/mul_4bits_seq.sv
// Sequential 4x4 unsigned shift-add multiplier with a three-state FSM.
// fa_4bits is the shared ripple-carry adder used for each partial-product step.

module fa_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    // NOTE: every variable driven here gets a value on every pass, so no latch is inferred.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[4];
    end

endmodule

module mul_4bits_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] i0,
    input  logic [3:0] i1,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] mcand;    // A: multiplicand captured at start
    logic [3:0] mplier;   // Q: multiplier, shifted out one bit per step
    logic [3:0] acc;      // P: upper half of the running product
    logic [1:0] count;

    logic [3:0] add_sum;
    logic       add_cout;
    logic [3:0] step_hi;
    logic       step_c;
    logic [7:0] step;
    logic       last_step;

    fa_4bits u_adder (
        .a    (acc),
        .b    (mcand),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Add the multiplicand only when the current multiplier LSB is set, then shift {c,P,Q} right.
    always_comb begin
        step_c  = 1'b0;
        step_hi = acc;
        if (mplier[0]) begin
            step_c  = add_cout;
            step_hi = add_sum;
        end
        step      = {step_c, step_hi, mplier[3:1]};
        last_step = (count == 2'd3);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_BUSY;
            ST_BUSY: if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_BUSY);
            done  <= (state_next == ST_DONE);
        end
    end

    // NOTE: every datapath register is reset, so an aborted operation leaves no stale operands behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= i0;
                        mplier <= i1;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                ST_BUSY: begin
                    acc    <= step[7:4];
                    mplier <= step[3:0];
                    count  <= count + 2'd1;
                    if (last_step) product <= step;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_4bits_seq.sv
// Self-checking bench for mul_4bits_seq: directed corner cases, random and exhaustive operands
// compared against plain multiplication, with cycle-exact busy/done timing.

module tb_mul_4bits_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] i0;
    logic [3:0] i1;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [7:0] prev_product;

    mul_4bits_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .i0      (i0),
        .i1      (i1),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected summary before it");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},    {7'd0, busy}, 8'd0);
        check({tag, "_done"},    {7'd0, done}, 8'd0);
        check({tag, "_product"}, product,      prev_product);
    endtask

    // Pulse start for one edge; during BUSY the operand inputs are changed to (sa, sb).
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] sa, input logic [3:0] sb);
        logic [7:0] expected;
        expected = 8'(a * b);
        @(negedge clk);
        i0    = a;
        i1    = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i0    = sa;
        i1    = sb;
        for (int k = 0; k < 4; k++) begin
            check("op_busy",         {7'd0, busy}, 8'd1);
            check("op_done_early",   {7'd0, done}, 8'd0);
            check("op_product_hold", product,      prev_product);
            @(negedge clk);
        end
        check("op_done",         {7'd0, done}, 8'd1);
        check("op_busy_in_done", {7'd0, busy}, 8'd0);
        check("op_product",      product,      expected);
        prev_product = expected;
        @(negedge clk);
        check_idle("op_after");
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        i0           = '0;
        i1           = '0;
        prev_product = 8'h00;

        // Reset acts without a clock edge.
        #1;
        check_idle("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check_idle("reset_idle");
        end

        // Corner values.
        do_op(4'd15, 4'd15, 4'd0, 4'd0);
        do_op(4'd0,  4'd9,  4'd15, 4'd15);

        // Operand isolation and product hold.
        do_op(4'd10, 4'd12, 4'd3, 4'd3);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check_idle("hold_78");
        end

        // Reset during the second BUSY cycle.
        @(negedge clk);
        i0    = 4'd7;
        i1    = 4'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy1", {7'd0, busy}, 8'd1);
        @(negedge clk);
        check("abort_busy2", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        prev_product = 8'h00;
        check_idle("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check_idle("abort_no_done");
        end
        do_op(4'd7, 4'd6, 4'd0, 4'd0);

        // Start held high: one result every six cycles.
        @(negedge clk);
        i0    = 4'd1;
        i1    = 4'd1;
        start = 1'b1;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            check("held_busy", {7'd0, busy}, {7'd0, (t % 6) < 4});
            check("held_done", {7'd0, done}, {7'd0, (t % 6) == 4});
            if (t >= 4) check("held_product", product, 8'h01);
        end
        start        = 1'b0;
        prev_product = 8'h01;
        @(negedge clk);
        check("held_last_busy", {7'd0, busy}, 8'd0);

        // Random operands with random disturbance of the inputs during BUSY.
        for (int n = 0; n < 24; n++) begin
            do_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_idle("rand_gap");
            end
        end

        // Every operand pair.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_op(4'(a), 4'(b), 4'($urandom), 4'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
